// File: rtl/sd_scan_pkg.sv
// Shared types and helpers for the SD block tag/word scanner.
package sd_scan_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_REQ,
    S_RECV,
    S_NEXT,
    S_DONE,
    S_ERR
  } state_e;

  localparam int unsigned BLOCK_BYTES = 512;
  localparam logic [7:0]  LF          = 8'h0A;

  // Letters and underscore are always word characters; digits optionally.
  function automatic logic is_word_char(input logic [7:0] c, input logic digits);
    logic upper;
    logic lower;
    logic uscore;
    logic digit;
    upper  = (c >= 8'h41) && (c <= 8'h5A);
    lower  = (c >= 8'h61) && (c <= 8'h7A);
    uscore = (c == 8'h5F);
    digit  = (c >= 8'h30) && (c <= 8'h39);
    return upper || lower || uscore || (digits && digit);
  endfunction

endpackage

// File: rtl/sd_tag_word_counter_tag_matcher.sv
// Streaming matcher for a fixed byte tag; restarts on tag[0] after a mismatch.
module tag_matcher #(
  parameter int unsigned            TAG_LEN = 9,
  parameter logic [8*TAG_LEN-1:0]   TAG     = "DLAB_TAG\n"
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       clr,
  input  logic       en,
  input  logic       byte_valid,
  input  logic [7:0] byte_in,
  output logic       found
);
  import sd_scan_pkg::*;

  localparam int unsigned IDX_W = $clog2(TAG_LEN + 1);

  logic [IDX_W-1:0] idx_q, idx_d;
  logic             found_q, found_d;
  logic [7:0]       exp_byte;
  logic             hit;

  // Select the expected tag byte and advance or restart the match index.
  always_comb begin
    exp_byte = '0;
    for (int unsigned i = 0; i < TAG_LEN; i++) begin
      if (idx_q == IDX_W'(i)) exp_byte = TAG[8*(TAG_LEN-1-i) +: 8];
    end
    idx_d   = idx_q;
    found_d = found_q;
    hit     = 1'b0;
    if (en && byte_valid && !found_q) begin
      if (byte_in == exp_byte) begin
        idx_d = idx_q + 1'b1;
        if (idx_q == IDX_W'(TAG_LEN - 1)) begin
          hit     = 1'b1;
          found_d = 1'b1;
        end
      end else begin
        idx_d = (byte_in == TAG[8*TAG_LEN-1 -: 8]) ? IDX_W'(1) : '0;
      end
    end
    if (clr) begin
      idx_d   = '0;
      found_d = 1'b0;
    end
  end

  // Match index and sticky found flag.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      idx_q   <= '0;
      found_q <= 1'b0;
    end else begin
      idx_q   <= idx_d;
      found_q <= found_d;
    end
  end

  // Found is visible on the completing byte itself so that byte can be excluded
  // from word counting.
  assign found = found_q | hit;

endmodule

// File: rtl/sd_tag_word_counter.sv
// Streams SD blocks, finds a begin tag and counts words of a chosen length
// up to the end tag.
module sd_tag_word_counter #(
  parameter int unsigned          TAG_LEN         = 9,
  parameter logic [8*TAG_LEN-1:0] BEGIN_TAG       = "DLAB_TAG\n",
  parameter logic [8*TAG_LEN-1:0] END_TAG         = "DLAB_END\n",
  parameter logic [31:0]          START_BLK       = 32'd0,
  parameter int unsigned          MAX_BLKS        = 4096,
  parameter int unsigned          CNT_W           = 16,
  parameter int unsigned          LEN_W           = 8,
  parameter bit                   DIGITS_ARE_WORD = 1'b0
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  input  logic [LEN_W-1:0] target_len,
  input  logic             sd_init_finished,
  output logic             sd_rd_req,
  output logic [31:0]      sd_block_addr,
  input  logic             sd_valid,
  input  logic [7:0]       sd_dout,
  output logic             busy,
  output logic             done,
  output logic             error,
  output logic             in_text,
  output logic [CNT_W-1:0] word_count,
  output logic [31:0]      blk_count
);
  import sd_scan_pkg::*;

  state_e           state_q, state_d;
  logic [31:0]      blk_q, blk_d;
  logic [9:0]       byte_q, byte_d;
  logic [LEN_W-1:0] len_q, len_d;
  logic [LEN_W-1:0] tlen_q, tlen_d;
  logic [CNT_W-1:0] wc_q, wc_d;
  logic             clr;
  logic             rx;
  logic             begin_found;
  logic             end_found;
  logic             text;

  assign rx   = (state_q == S_RECV) && sd_valid;
  assign text = begin_found && !end_found;

  tag_matcher #(
    .TAG_LEN (TAG_LEN),
    .TAG     (BEGIN_TAG)
  ) u_begin (
    .clk        (clk),
    .reset_n    (reset_n),
    .clr        (clr),
    .en         (1'b1),
    .byte_valid (rx),
    .byte_in    (sd_dout),
    .found      (begin_found)
  );

  tag_matcher #(
    .TAG_LEN (TAG_LEN),
    .TAG     (END_TAG)
  ) u_end (
    .clk        (clk),
    .reset_n    (reset_n),
    .clr        (clr),
    .en         (begin_found),
    .byte_valid (rx),
    .byte_in    (sd_dout),
    .found      (end_found)
  );

  // Next-state, block/byte sequencing and word counting.
  always_comb begin
    state_d = state_q;
    blk_d   = blk_q;
    byte_d  = byte_q;
    len_d   = len_q;
    tlen_d  = tlen_q;
    wc_d    = wc_q;
    clr     = 1'b0;
    case (state_q)
      S_IDLE, S_DONE, S_ERR: begin
        if (start && sd_init_finished) begin
          clr     = 1'b1;
          blk_d   = '0;
          byte_d  = '0;
          len_d   = '0;
          wc_d    = '0;
          tlen_d  = target_len;
          state_d = S_REQ;
        end
      end
      S_REQ: begin
        byte_d  = '0;
        state_d = S_RECV;
      end
      S_RECV: begin
        if (sd_valid) begin
          byte_d = byte_q + 1'b1;
          if (byte_q == 10'(BLOCK_BYTES - 1)) state_d = S_NEXT;
          if (text) begin
            if (is_word_char(sd_dout, DIGITS_ARE_WORD)) begin
              if (len_q != '1) len_d = len_q + 1'b1;
            end else begin
              len_d = '0;
              if ((len_q != '0) && ((tlen_q == '0) || (len_q == tlen_q)) && (wc_q != '1))
                wc_d = wc_q + 1'b1;
            end
          end
        end
      end
      S_NEXT: begin
        blk_d = blk_q + 1'b1;
        if (end_found)                       state_d = S_DONE;
        else if (blk_q + 1'b1 == 32'(MAX_BLKS)) state_d = S_ERR;
        else                                 state_d = S_REQ;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      blk_q   <= '0;
      byte_q  <= '0;
      len_q   <= '0;
      tlen_q  <= '0;
      wc_q    <= '0;
    end else begin
      state_q <= state_d;
      blk_q   <= blk_d;
      byte_q  <= byte_d;
      len_q   <= len_d;
      tlen_q  <= tlen_d;
      wc_q    <= wc_d;
    end
  end

  // Request and busy are gated by reset so an abort drops them immediately.
  assign sd_rd_req     = reset_n && (state_q == S_REQ);
  assign busy          = reset_n && ((state_q == S_REQ) || (state_q == S_RECV) || (state_q == S_NEXT));
  assign done          = (state_q == S_DONE);
  assign error         = (state_q == S_ERR);
  assign in_text       = text;
  assign sd_block_addr = START_BLK + blk_q;
  assign word_count    = wc_q;
  assign blk_count     = blk_q;

endmodule

// File: tb/tb_sd_tag_word_counter.sv
// Directed bench for sd_tag_word_counter with a simple SD byte-stream model.
module tb_sd_tag_word_counter;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        sd_init_finished;
  logic        sd_valid;
  logic [7:0]  sd_dout;
  logic [7:0]  target_len;
  logic        start_a, start_b;

  logic        rd_req_a, busy_a, done_a, error_a, in_text_a;
  logic [31:0] addr_a, blk_a;
  logic [15:0] wc_a;
  logic        rd_req_b, busy_b, done_b, error_b, in_text_b;
  logic [31:0] addr_b, blk_b;
  logic [1:0]  wc_b;

  int checks = 0;
  int errors = 0;
  int req_cnt_a = 0;
  int req_cnt_b = 0;
  int sel = 0;
  logic [7:0] mem [0:1535];

  always #5 clk = ~clk;

  sd_tag_word_counter #(.MAX_BLKS(4)) dut_a (
    .clk(clk), .reset_n(reset_n), .start(start_a), .target_len(target_len),
    .sd_init_finished(sd_init_finished), .sd_rd_req(rd_req_a), .sd_block_addr(addr_a),
    .sd_valid(sd_valid), .sd_dout(sd_dout), .busy(busy_a), .done(done_a),
    .error(error_a), .in_text(in_text_a), .word_count(wc_a), .blk_count(blk_a)
  );

  sd_tag_word_counter #(.MAX_BLKS(2), .CNT_W(2)) dut_b (
    .clk(clk), .reset_n(reset_n), .start(start_b), .target_len(target_len),
    .sd_init_finished(sd_init_finished), .sd_rd_req(rd_req_b), .sd_block_addr(addr_b),
    .sd_valid(sd_valid), .sd_dout(sd_dout), .busy(busy_b), .done(done_b),
    .error(error_b), .in_text(in_text_b), .word_count(wc_b), .blk_count(blk_b)
  );

  // Count request cycles per instance.
  always @(posedge clk) begin
    if (rd_req_a) req_cnt_a <= req_cnt_a + 1;
    if (rd_req_b) req_cnt_b <= req_cnt_b + 1;
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic clear_mem();
    for (int i = 0; i < 1536; i++) mem[i] = 8'h2E;
  endtask

  task automatic put(input int pos, input string s);
    for (int i = 0; i < s.len(); i++) mem[pos + i] = s[i];
  endtask

  function automatic logic cur_req();
    return (sel != 0) ? rd_req_b : rd_req_a;
  endfunction

  function automatic logic [31:0] cur_addr();
    return (sel != 0) ? addr_b : addr_a;
  endfunction

  function automatic logic cur_fin();
    return (sel != 0) ? (done_b | error_b) : (done_a | error_a);
  endfunction

  task automatic pulse_start(input int which);
    @(posedge clk); #1;
    if (which == 0) start_a = 1'b1; else start_b = 1'b1;
    @(posedge clk); #1;
    start_a = 1'b0;
    start_b = 1'b0;
  endtask

  task automatic serve(input int blk, input int nbytes);
    int  n = 0;
    bit  seen = 1'b0;
    while (!seen && n < 100) begin
      @(negedge clk);
      if (cur_req()) seen = 1'b1;
      n++;
    end
    chk("req_seen", 64'(seen), 64'd1);
    if (seen) begin
      chk("req_addr", 64'(cur_addr()), 64'(blk));
      for (int i = 0; i < nbytes; i++) begin
        @(posedge clk); #1;
        if (i % 97 == 50) begin
          sd_valid = 1'b0;
          @(posedge clk); #1;
        end
        sd_valid = 1'b1;
        sd_dout  = mem[blk * 512 + i];
      end
      @(posedge clk); #1;
      sd_valid = 1'b0;
    end
  endtask

  task automatic wait_fin();
    int n = 0;
    while (!cur_fin() && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("finish_seen", 64'(cur_fin()), 64'd1);
  endtask

  initial begin
    reset_n = 1'b0; sd_init_finished = 1'b0; sd_valid = 1'b0; sd_dout = '0;
    target_len = '0; start_a = 1'b0; start_b = 1'b0;
    repeat (3) @(posedge clk);
    #1 reset_n = 1'b1;

    // Reset state
    @(negedge clk);
    chk("rst_busy", 64'(busy_a), 0);
    chk("rst_req", 64'(rd_req_a), 0);
    chk("rst_done", 64'(done_a), 0);
    chk("rst_error", 64'(error_a), 0);
    chk("rst_in_text", 64'(in_text_a), 0);
    chk("rst_wc", 64'(wc_a), 0);
    chk("rst_blk", 64'(blk_a), 0);
    chk("rst_addr", 64'(addr_a), 0);

    // Start ignored while the SD controller is not ready
    pulse_start(0);
    repeat (5) @(negedge clk);
    chk("noinit_busy", 64'(busy_a), 0);
    chk("noinit_reqs", 64'(req_cnt_a), 0);
    sd_init_finished = 1'b1;

    // Single block, target length 3
    sel = 0;
    clear_mem();
    put(0, "xxDLAB_TAG\nab cde fgh ijkl\nDLAB_END\n");
    target_len = 8'd3;
    pulse_start(0);
    serve(0, 512);
    wait_fin();
    chk("t3_done", 64'(done_a), 1);
    chk("t3_error", 64'(error_a), 0);
    chk("t3_wc", 64'(wc_a), 2);
    chk("t3_blk", 64'(blk_a), 1);
    chk("t3_busy", 64'(busy_a), 0);
    chk("t3_in_text", 64'(in_text_a), 0);
    chk("t3_reqs", 64'(req_cnt_a), 1);

    // Restart from S_DONE, count all words
    target_len = 8'd0;
    pulse_start(0);
    chk("rs_done_clr", 64'(done_a), 0);
    chk("rs_wc_clr", 64'(wc_a), 0);
    chk("rs_blk_clr", 64'(blk_a), 0);
    chk("rs_busy", 64'(busy_a), 1);
    serve(0, 512);
    wait_fin();
    chk("t0_wc", 64'(wc_a), 4);
    chk("t0_reqs", 64'(req_cnt_a), 2);

    // Target 8: only the end tag has 8 letters and it must not count
    target_len = 8'd8;
    pulse_start(0);
    serve(0, 512);
    wait_fin();
    chk("t8_done", 64'(done_a), 1);
    chk("t8_wc", 64'(wc_a), 0);

    // Begin tag split across blocks 0/1, word straddling 1/2, end tag in block 2
    clear_mem();
    put(505, "DLAB_TAG\n");
    put(514, "one two ");
    put(512 + 509, "str");
    put(1024, "addle cat\nDLAB_END\n");
    target_len = 8'd8;
    pulse_start(0);
    serve(0, 512);
    serve(1, 512);
    serve(2, 512);
    wait_fin();
    chk("split_done", 64'(done_a), 1);
    chk("split_wc", 64'(wc_a), 1);
    chk("split_blk", 64'(blk_a), 3);
    chk("split_reqs", 64'(req_cnt_a), 6);
    chk("split_in_text", 64'(in_text_a), 0);

    // Overlapping begin tag, saturating 2-bit count, no end tag -> error
    sel = 1;
    clear_mem();
    put(0, "DDLAB_TAG\naa bb cc dd ee ");
    target_len = 8'd2;
    pulse_start(1);
    serve(0, 512);
    serve(1, 512);
    wait_fin();
    chk("err_error", 64'(error_b), 1);
    chk("err_done", 64'(done_b), 0);
    chk("err_blk", 64'(blk_b), 2);
    chk("sat_wc", 64'(wc_b), 3);
    chk("ovl_in_text", 64'(in_text_b), 1);
    chk("err_busy", 64'(busy_b), 0);
    repeat (20) @(negedge clk);
    chk("err_reqs", 64'(req_cnt_b), 2);

    // Reset during S_RECV
    sel = 0;
    clear_mem();
    put(0, "DLAB_TAG\nab cd ");
    target_len = 8'd0;
    pulse_start(0);
    serve(0, 40);
    @(negedge clk);
    chk("mid_in_text", 64'(in_text_a), 1);
    chk("mid_wc", 64'(wc_a), 2);
    chk("mid_busy", 64'(busy_a), 1);
    @(posedge clk); #1;
    reset_n = 1'b0;
    #1;
    chk("abort_busy", 64'(busy_a), 0);
    chk("abort_req", 64'(rd_req_a), 0);
    @(posedge clk); #1;
    chk("abort_wc", 64'(wc_a), 0);
    chk("abort_in_text", 64'(in_text_a), 0);
    chk("abort_blk", 64'(blk_a), 0);
    chk("abort_done", 64'(done_a), 0);
    chk("abort_addr", 64'(addr_a), 0);
    reset_n = 1'b1;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
